// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch front end.
//   XLEN             : width of PC and instruction words
//   RESET_PC_DEFAULT : default PC loaded on reset
//   NOP_INSTR        : canonical no-op used downstream for bubble insertion
//   fetch_entry_t    : one prefetch FIFO entry, PC in the upper half
// ----------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Small synchronous FIFO with a registered head output.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle (ignored when full)
//   push_data  : entry to write
//   pop        : remove the head this cycle (ignored when empty)
//   flush      : empty the FIFO; wins over push in the same cycle
//   count      : current occupancy (0..DEPTH)
//   head       : oldest entry, registered; holds last value when empty
//   not_empty  : registered (count != 0)
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic [WIDTH-1:0]        head,
  output logic                    not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_inc_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_next_s;
  logic             not_empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s     = pop && (count_r != ZERO_CNT);
  assign push_ok_s    = push && (count_r != FULL_CNT);
  assign rd_ptr_inc_s = rd_ptr_r + AW'(1);

  assign count     = count_r;
  assign head      = head_r;
  assign not_empty = not_empty_r;

  // Next occupancy from flush / push / pop.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = ZERO_CNT;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_next_s = count_r + ONE_CNT;
        2'b01:   count_next_s = count_r - ONE_CNT;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Next head: the new word when it lands in an empty (or emptying) FIFO,
  // otherwise the entry behind the current head on a pop.
  always_comb begin
    head_next_s = head_r;
    if (flush) begin
      head_next_s = head_r;
    end else if (count_r == ZERO_CNT) begin
      if (push_ok_s) begin
        head_next_s = push_data;
      end else begin
        head_next_s = head_r;
      end
    end else if (pop_ok_s) begin
      if (count_r == ONE_CNT) begin
        if (push_ok_s) begin
          head_next_s = push_data;
        end else begin
          head_next_s = head_r;
        end
      end else begin
        head_next_s = mem_r[rd_ptr_inc_s];
      end
    end else begin
      head_next_s = head_r;
    end
  end

  // Storage, pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= ZERO_CNT;
      head_r      <= {WIDTH{1'b0}};
      not_empty_r <= 1'b0;
    end else begin
      if (push_ok_s && !flush) begin
        mem_r[wr_ptr_r] <= push_data;
      end
      if (flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_ok_s)  rd_ptr_r <= rd_ptr_inc_s;
      end
      count_r     <= count_next_s;
      head_r      <= head_next_s;
      not_empty_r <= (count_next_s != ZERO_CNT);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch front end: owns the PC, issues sequential reads to a synchronous
// program memory and buffers returned words in a prefetch FIFO.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req/addr   : read request and address (address = current PC)
//   imem_rdata      : read data, one cycle after the request
//   redirect_valid  : restart fetch at redirect_pc, flushing queued words
//   redirect_pc     : new fetch address (not alignment-checked)
//   out_valid       : head instruction valid
//   out_instr/out_pc: head instruction and its PC (registered)
//   out_ready       : decode accepts the head this cycle
//   fifo_count      : current FIFO occupancy
// A request is issued only while FIFO occupancy plus the outstanding request
// leaves room, so a returning word always has a free slot.
// ----------------------------------------------------------------------------
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              PC_STEP  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int              CW           = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_CREDIT = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP         = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] tag_pc_r;
  logic            inflight_r;
  logic            squash_r;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic [CW:0]     credit_used_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

  assign credit_used_s = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_r};
  // Gated by rst so no request is presented while reset is held.
  assign issue_s   = !rst && !redirect_valid && (credit_used_s < DEPTH_CREDIT);
  assign imem_req  = issue_s;
  assign imem_addr = pc_r;

  assign push_entry_s = {tag_pc_r, imem_rdata};
  assign push_s       = inflight_r && !squash_r;
  assign pop_s        = out_valid && out_ready;

  assign out_pc    = head_s.pc;
  assign out_instr = head_s.instr;

  // PC, outstanding-request tracking and response squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      tag_pc_r   <= {XLEN{1'b0}};
      inflight_r <= 1'b0;
      squash_r   <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (issue_s) begin
        pc_r <= pc_r + STEP;
      end
      if (issue_s) begin
        tag_pc_r <= pc_r;
      end
      inflight_r <= issue_s;
      squash_r   <= redirect_valid && inflight_r;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head      (head_s),
    .not_empty (out_valid)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench. Memory returns addr ^ 32'hA5A5_0000. The stimulus pushes
// the PCs it expects decode to receive; an independent monitor pops and
// compares on every out_valid && out_ready handshake.
// ----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic [2:0]  fifo_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .fifo_count     (fifo_count)
  );

  // Synchronous program memory model.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted instruction must be the next expected.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_delivery: got pc %h, want none", out_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        check("deliver_pc", out_pc, mon_pc);
        check("deliver_instr", out_instr, mon_pc ^ K);
      end
    end
  end

  initial begin
    // ---- reset values
    repeat (3) step();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);

    // ---- streaming from RESET_PC with out_ready high
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(32'(k * 4));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("a_imem_req", 32'(imem_req), 32'h1);
      check("a_imem_addr", imem_addr, 32'(k * 4));
      check("a_out_valid", 32'(out_valid), 32'(k >= 2));
      step();
    end
    out_ready = 1'b0;
    check("a_drained", 32'(exp_q.size()), 32'h0);

    // ---- asynchronous reset mid-stream, not clock aligned
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'h0);
    check("mrst_fifo_count", 32'(fifo_count), 32'h0);
    check("mrst_imem_req", 32'(imem_req), 32'h0);
    check("mrst_out_pc", out_pc, 32'h0);
    check("mrst_out_instr", out_instr, 32'h0);
    repeat (2) step();
    rst = 1'b0;

    // ---- stall: FIFO fills to 4, then drains gap-free into 0x10, 0x14
    for (int c = 0; c < 6; c++) exp_q.push_back(32'(c * 4));
    for (int c = 0; c < 16; c++) begin
      out_ready = (c >= 10);
      @(negedge clk);
      if (c < 4) begin
        check("b_imem_req", 32'(imem_req), 32'h1);
        check("b_imem_addr", imem_addr, 32'(c * 4));
      end
      if (c == 9) begin
        check("b_full_count", 32'(fifo_count), 32'h4);
        check("b_full_req", 32'(imem_req), 32'h0);
        check("b_pc_hold", imem_addr, 32'h0000_0010);
      end
      if (c >= 10) check("b_no_gap", 32'(out_valid), 32'h1);
      step();
    end

    // ---- redirects: in-flight flush, coincident pop, PC wrap
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_0204);
    for (int r = 0; r < 17; r++) begin
      case (r)
        0: begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b0; end
        1: begin redirect_valid = 1'b0; out_ready = 1'b1; end
        5: begin
          redirect_valid = 1'b1; redirect_pc = 32'h0000_0000; out_ready = 1'b0;
          exp_q.push_back(32'h0000_0000);
          exp_q.push_back(32'h0000_0004);
          exp_q.push_back(32'h0000_0008);
          exp_q.push_back(32'hFFFF_FFF8);
          exp_q.push_back(32'hFFFF_FFFC);
          exp_q.push_back(32'h0000_0000);
        end
        6:  begin redirect_valid = 1'b0; out_ready = 1'b1; end
        10: begin redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; end
        11: redirect_valid = 1'b0;
        16: out_ready = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      case (r)
        0: begin
          check("c_count_at_redirect", 32'(fifo_count), 32'h2);
          check("c_req_in_redirect", 32'(imem_req), 32'h0);
        end
        1: begin
          check("c_req_after", 32'(imem_req), 32'h1);
          check("c_addr_after", imem_addr, 32'h0000_0200);
          check("c_valid_gap1", 32'(out_valid), 32'h0);
        end
        2: begin
          check("c_addr_next", imem_addr, 32'h0000_0204);
          check("c_valid_gap2", 32'(out_valid), 32'h0);
        end
        3: begin
          check("c_valid_r3", 32'(out_valid), 32'h1);
          check("c_pc_r3", out_pc, 32'h0000_0200);
        end
        5: check("d_req_in_redirect", 32'(imem_req), 32'h0);
        6: check("d_addr_after", imem_addr, 32'h0000_0000);
        10: begin
          check("d_req_in_redirect2", 32'(imem_req), 32'h0);
          check("d_head_pop", out_pc, 32'h0000_0008);
        end
        11: begin
          check("w_addr0", imem_addr, 32'hFFFF_FFF8);
          check("w_valid_gap1", 32'(out_valid), 32'h0);
        end
        12: begin
          check("w_addr1", imem_addr, 32'hFFFF_FFFC);
          check("w_valid_gap2", 32'(out_valid), 32'h0);
        end
        13: begin
          check("w_addr_wrap", imem_addr, 32'h0000_0000);
          check("w_valid_r3", 32'(out_valid), 32'h1);
        end
        default: ;
      endcase
      step();
    end

    repeat (3) step();
    check("all_delivered", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
